// File: rtl/sopc_base_cpu_debug_cmd_sync_if.sv
// Debug command bus between the TCK-domain shifter and the sysclk decoder.
// Latency: none, this is wires only.
// Backpressure: cmd_ready from the consumer side qualifies the strobes.
// Ports: ir_in/sr/vs_udr_tgl/vs_uir_tgl come from the shifter; cmd_ready and
//        overrun_clr come from the consumer; jdo/jdo_ir/cmd_pending/strobes,
//        uir_pulse and overrun go back out of the decoder.
interface sopc_base_cpu_debug_cmd_sync_if #(
   parameter int IR_WIDTH = 2,
   parameter int DR_WIDTH = 38
);
   localparam int N_CMD = 2 ** IR_WIDTH;

   logic [IR_WIDTH-1:0] ir_in;
   logic [DR_WIDTH-1:0] sr;
   logic                vs_udr_tgl;
   logic                vs_uir_tgl;
   logic                cmd_ready;
   logic                overrun_clr;
   logic [DR_WIDTH-1:0] jdo;
   logic [IR_WIDTH-1:0] jdo_ir;
   logic                cmd_pending;
   logic [N_CMD-1:0]    take_action;
   logic [N_CMD-1:0]    take_no_action;
   logic                uir_pulse;
   logic                overrun;

   // Decoder side.
   modport slave (
      input  ir_in, sr, vs_udr_tgl, vs_uir_tgl, cmd_ready, overrun_clr,
      output jdo, jdo_ir, cmd_pending, take_action, take_no_action,
             uir_pulse, overrun
   );

   // Shifter / consumer side.
   modport master (
      output ir_in, sr, vs_udr_tgl, vs_uir_tgl, cmd_ready, overrun_clr,
      input  jdo, jdo_ir, cmd_pending, take_action, take_no_action,
             uir_pulse, overrun
   );
endinterface

// File: rtl/sopc_base_cpu_debug_cmd_sync.sv
// Sysclk-side debug command synchroniser: syncs update toggles, latches IR/DR, issues one-hot strobes.
// Latency: udr toggle -> cmd_pending in SYNC_STAGES+1 clocks; uir toggle -> uir_pulse in SYNC_STAGES+2.
// Backpressure: a command is held until cmd_ready; an update-DR arriving while held is dropped and flags overrun.
// Ports: clk, reset_n (async active-low); bus = slave modport of the command interface.
module sopc_base_cpu_debug_cmd_sync #(
   parameter int IR_WIDTH    = 2,
   parameter int DR_WIDTH    = 38,
   parameter int ACT_BIT     = 37,   // must be < DR_WIDTH
   parameter int SYNC_STAGES = 2     // legal range 2..4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   sopc_base_cpu_debug_cmd_sync_if.slave bus
);
   localparam int N_CMD = 2 ** IR_WIDTH;
   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic                   udr_prev_q, uir_prev_q;
   logic [2:0]             arm_cnt_q, arm_cnt_d;
   logic                   uir_edge_q;
   logic                   uir_pulse_q;
   logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
   logic [IR_WIDTH-1:0]    jdo_ir_q, jdo_ir_d;
   logic                   pending_q, pending_d;
   logic                   overrun_q, overrun_d;

   logic armed, udr_edge, uir_edge, consume, accept, drop;

   always_comb begin
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr_tgl};
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir_tgl};
      armed      = (arm_cnt_q == ARM_MAX);
      arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 3'd1;

      // prev always follows the sync output; edges only count once armed so
      // a toggle line parked high across reset never looks like an update.
      udr_edge = armed & (udr_sync_q[SYNC_STAGES-1] != udr_prev_q);
      uir_edge = armed & (uir_sync_q[SYNC_STAGES-1] != uir_prev_q);

      consume = pending_q & bus.cmd_ready;
      // Back-to-back: a command consumed this cycle frees the slot for the new one.
      accept  = udr_edge & (~pending_q | bus.cmd_ready);
      drop    = udr_edge & pending_q & ~bus.cmd_ready;

      jdo_d     = jdo_q;
      jdo_ir_d  = jdo_ir_q;
      pending_d = pending_q;
      if (accept) begin
         jdo_d     = bus.sr;
         jdo_ir_d  = bus.ir_in;
         pending_d = 1'b1;
      end else if (consume) begin
         pending_d = 1'b0;
      end

      // Setting wins over clearing so a coincident overrun is never lost.
      overrun_d = overrun_q;
      if (drop)
         overrun_d = 1'b1;
      else if (bus.overrun_clr)
         overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync_q  <= '0;
         uir_sync_q  <= '0;
         udr_prev_q  <= 1'b0;
         uir_prev_q  <= 1'b0;
         arm_cnt_q   <= '0;
         uir_edge_q  <= 1'b0;
         uir_pulse_q <= 1'b0;
         jdo_q       <= '0;
         jdo_ir_q    <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         udr_sync_q  <= udr_sync_d;
         uir_sync_q  <= uir_sync_d;
         udr_prev_q  <= udr_sync_q[SYNC_STAGES-1];
         uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
         arm_cnt_q   <= arm_cnt_d;
         // Two registers on the IR path so uir_pulse lands one cycle after
         // a DR command from an equally-timed toggle would be latched.
         uir_edge_q  <= uir_edge;
         uir_pulse_q <= uir_edge_q;
         jdo_q       <= jdo_d;
         jdo_ir_q    <= jdo_ir_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
      end
   end

   logic [N_CMD-1:0] lane;
   always_comb begin
      lane = N_CMD'(1) << jdo_ir_q;
      bus.take_action    = (consume &  jdo_q[ACT_BIT]) ? lane : '0;
      bus.take_no_action = (consume & ~jdo_q[ACT_BIT]) ? lane : '0;
   end

   assign bus.jdo         = jdo_q;
   assign bus.jdo_ir      = jdo_ir_q;
   assign bus.cmd_pending = pending_q;
   assign bus.uir_pulse   = uir_pulse_q;
   assign bus.overrun     = overrun_q;
endmodule
